// File: rtl/armleocpu_stream_serializer.sv
// Wide-to-narrow valid/ready serializer: one RATIO-lane word in, up to RATIO
// narrow beats out, least-significant lane first, final beat flagged by out_last.
module armleocpu_stream_serializer #(
  parameter int DW    = 8,
  parameter int RATIO = 4,
  parameter int CW    = $clog2(RATIO + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DW*RATIO-1:0]   in_data,
  input  logic [CW-1:0]         in_count,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DW-1:0]         out_data,
  output logic                  out_last,
  input  logic                  out_ready
);

  localparam int WW = DW * RATIO;
  localparam logic [CW-1:0] RATIO_C = CW'(RATIO);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] TWO_C   = CW'(32'd2);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic [WW-1:0]   sreg_r;
  logic [WW-1:0]   sreg_nx_s;
  logic [CW-1:0]   rem_r;
  logic [CW-1:0]   rem_nx_s;
  logic            last_r;
  logic            last_nx_s;
  logic [CW-1:0]   count_eff_s;
  logic            accept_s;

  // A new word may enter while idle, or on the very cycle the last beat leaves.
  assign in_ready  = !rst && ((state_r == ST_IDLE) || (out_ready && last_r));
  assign out_valid = (state_r == ST_BUSY);
  assign out_data  = sreg_r[DW-1:0];
  assign out_last  = last_r;

  // Clamp out-of-range lane counts to a full word.
  always_comb begin
    count_eff_s = in_count;
    if ((in_count == ZERO_C) || (in_count > RATIO_C)) begin
      count_eff_s = RATIO_C;
    end else begin
      count_eff_s = in_count;
    end
  end

  // Next-state: accept has priority over retiring the last beat.
  always_comb begin
    state_nx_s = state_r;
    sreg_nx_s  = sreg_r;
    rem_nx_s   = rem_r;
    last_nx_s  = last_r;
    accept_s   = in_valid && in_ready;
    if (accept_s) begin
      state_nx_s = ST_BUSY;
      sreg_nx_s  = in_data;
      rem_nx_s   = count_eff_s;
      last_nx_s  = (count_eff_s == ONE_C);
    end else begin
      case (state_r)
        ST_BUSY: begin
          if (out_ready && last_r) begin
            state_nx_s = ST_IDLE;
            rem_nx_s   = ZERO_C;
            last_nx_s  = 1'b0;
          end else if (out_ready) begin
            sreg_nx_s  = sreg_r >> DW;
            rem_nx_s   = rem_r - ONE_C;
            last_nx_s  = (rem_r == TWO_C);
          end else begin
            state_nx_s = ST_BUSY;
          end
        end
        ST_IDLE: state_nx_s = ST_IDLE;
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset that drops any in-flight word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sreg_r  <= {WW{1'b0}};
      rem_r   <= ZERO_C;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      sreg_r  <= sreg_nx_s;
      rem_r   <= rem_nx_s;
      last_r  <= last_nx_s;
    end
  end

endmodule

// File: tb/tb_armleocpu_stream_serializer.sv
// Directed bench for armleocpu_stream_serializer (DW=8, RATIO=4) with a beat
// scoreboard filled on word acceptance and drained on output handshakes.
module tb_armleocpu_stream_serializer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic [2:0]  in_count;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;

  beat_t sb[$];
  int    checks;
  int    failures;
  logic        o_ir;
  logic        o_ov;
  logic [7:0]  o_od;
  logic        o_ol;

  armleocpu_stream_serializer #(.DW(8), .RATIO(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_count  (in_count),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample #1 later, score handshakes, advance.
  task automatic cyc(input logic v, input logic [31:0] d, input logic [2:0] c,
                     input logic ordy, input logic r);
    beat_t e;
    int    eff;
    rst = r; in_valid = v; in_data = d; in_count = c; out_ready = ordy;
    #1;
    o_ir = in_ready; o_ov = out_valid; o_od = out_data; o_ol = out_last;
    if (r) begin
      sb.delete();
    end else begin
      if (o_ov && ordy) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'(o_ov), 32'd0);
        end else begin
          e = sb.pop_front();
          check("beat_data", 32'(o_od), 32'(e.data));
          check("beat_last", 32'(o_ol), 32'(e.last));
        end
      end
      if (v && o_ir) begin
        eff = ((c == 3'd0) || (c > 3'd4)) ? 4 : int'(c);
        for (int k = 0; k < eff; k++) begin
          e.data = d[k*8 +: 8];
          e.last = (k == eff - 1);
          sb.push_back(e);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [31:0] W_A  = 32'hDDCCBBAA;
  localparam logic [31:0] W_B1 = 32'h44332211;
  localparam logic [31:0] W_B2 = 32'h88776655;
  localparam logic [31:0] W_C  = 32'h0F0E0D0C;
  localparam logic [31:0] JUNK = 32'hFFFFFFFF;

  initial begin
    logic [2:0] cnts [4];
    int         nexp [4];
    checks = 0; failures = 0;
    cnts = '{3'd2, 3'd0, 3'd7, 3'd1};
    nexp = '{2, 4, 4, 1};
    rst = 1'b1; in_valid = 1'b1; in_data = W_A; in_count = 3'd4; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Reset held with in_valid high
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, W_A, 3'd4, 1'b1, 1'b1);
      check("rst_in_ready", 32'(o_ir), 32'd0);
      check("rst_out_valid", 32'(o_ov), 32'd0);
      check("rst_out_data", 32'(o_od), 32'd0);
      check("rst_out_last", 32'(o_ol), 32'd0);
    end

    // Full word, first accept right after reset
    cyc(1'b1, W_A, 3'd4, 1'b1, 1'b0);
    check("post_rst_in_ready", 32'(o_ir), 32'd1);
    check("accept_out_valid", 32'(o_ov), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, JUNK, 3'd1, 1'b1, 1'b0);
      check("full_out_valid", 32'(o_ov), 32'd1);
      check("full_in_ready", 32'(o_ir), (i == 3) ? 32'd1 : 32'd0);
    end
    cyc(1'b0, JUNK, 3'd1, 1'b1, 1'b0);
    check("full_idle", 32'(o_ov), 32'd0);

    // Partial and out-of-range counts; in_data changes while busy are ignored
    for (int t = 0; t < 4; t++) begin
      cyc(1'b1, W_A, cnts[t], 1'b1, 1'b0);
      check("part_accept", 32'(o_ir), 32'd1);
      for (int i = 0; i < nexp[t]; i++) begin
        cyc(1'b0, JUNK, 3'd4, 1'b1, 1'b0);
        check("part_out_valid", 32'(o_ov), 32'd1);
      end
      cyc(1'b0, JUNK, 3'd4, 1'b1, 1'b0);
      check("part_idle", 32'(o_ov), 32'd0);
    end

    // Back-to-back words with in_valid held
    cyc(1'b1, W_B1, 3'd4, 1'b1, 1'b0);
    check("b2b_accept1", 32'(o_ir), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, W_B2, 3'd4, 1'b1, 1'b0);
      check("b2b_out_valid1", 32'(o_ov), 32'd1);
      check("b2b_in_ready", 32'(o_ir), (i == 3) ? 32'd1 : 32'd0);
    end
    check("b2b_swap_data", 32'(o_od), 32'h44);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, JUNK, 3'd4, 1'b1, 1'b0);
      check("b2b_out_valid2", 32'(o_ov), 32'd1);
    end
    cyc(1'b0, JUNK, 3'd4, 1'b1, 1'b0);
    check("b2b_idle", 32'(o_ov), 32'd0);

    // Backpressure on the second beat
    cyc(1'b1, W_A, 3'd4, 1'b1, 1'b0);
    cyc(1'b0, JUNK, 3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h11111111, 3'd4, 1'b0, 1'b0);
      check("bp_out_data", 32'(o_od), 32'hBB);
      check("bp_out_valid", 32'(o_ov), 32'd1);
      check("bp_in_ready", 32'(o_ir), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, JUNK, 3'd4, 1'b1, 1'b0);
      check("bp_resume_valid", 32'(o_ov), 32'd1);
    end
    cyc(1'b0, JUNK, 3'd4, 1'b1, 1'b0);
    check("bp_idle", 32'(o_ov), 32'd0);

    // Reset mid-word after two beats
    cyc(1'b1, W_A, 3'd4, 1'b1, 1'b0);
    cyc(1'b0, JUNK, 3'd4, 1'b1, 1'b0);
    cyc(1'b0, JUNK, 3'd4, 1'b1, 1'b0);
    cyc(1'b0, JUNK, 3'd4, 1'b1, 1'b1);
    check("midrst_in_ready", 32'(o_ir), 32'd0);
    cyc(1'b1, W_C, 3'd4, 1'b1, 1'b0);
    check("midrst_out_valid", 32'(o_ov), 32'd0);
    check("midrst_out_data", 32'(o_od), 32'd0);
    check("midrst_in_ready2", 32'(o_ir), 32'd1);
    cyc(1'b0, JUNK, 3'd4, 1'b1, 1'b0);
    check("midrst_first", 32'(o_od), 32'h0C);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, JUNK, 3'd4, 1'b1, 1'b0);
      check("midrst_out_valid2", 32'(o_ov), 32'd1);
    end
    cyc(1'b0, JUNK, 3'd4, 1'b1, 1'b0);
    check("midrst_idle", 32'(o_ov), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
